// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream over valid/ready, packs
// little-endian 32-bit words, writes them to instruction memory at consecutive
// word addresses, and releases cpu_hold only after the stream checksum matches.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [15:0] words_loaded,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [23:0]        word_buf_q, word_buf_d;
    logic [7:0]         csum_q, csum_d;
    logic [LEN_W-1:0]   words_loaded_q, words_loaded_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [31:0]        wr_data_q, wr_data_d;

    logic               accept_c;
    logic [LEN_W-1:0]   len_full_c;
    logic               last_word_c;

    assign accept_c    = in_valid && in_ready_q;
    assign len_full_c  = {in_byte, len_q[7:0]};
    assign last_word_c = (words_loaded_q + 16'd1) == len_q;

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            len_q          <= '0;
            byte_idx_q     <= '0;
            word_buf_q     <= '0;
            csum_q         <= '0;
            words_loaded_q <= '0;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            cpu_hold_q     <= 1'b1;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= BASE_ADDR;
            wr_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            byte_idx_q     <= byte_idx_d;
            word_buf_q     <= word_buf_d;
            csum_q         <= csum_d;
            words_loaded_q <= words_loaded_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
            cpu_hold_q     <= cpu_hold_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
        end
    end

    // Next-state: walk the stream format, start only honoured when not busy
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_d = S_LEN0;
            end
            S_LEN0: begin
                if (accept_c) state_d = S_LEN1;
            end
            S_LEN1: begin
                if (accept_c) begin
                    if (len_full_c == '0)                  state_d = S_CSUM;
                    else if (32'(len_full_c) > MAX_WORDS)  state_d = S_ERR;
                    else                                   state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept_c && (byte_idx_q == 2'd3) && last_word_c) state_d = S_CSUM;
            end
            S_CSUM: begin
                if (accept_c) state_d = (in_byte == csum_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath: status follows the next state, words pack on the 4th byte
    always_comb begin
        len_d          = len_q;
        byte_idx_d     = byte_idx_q;
        word_buf_d     = word_buf_q;
        csum_d         = csum_q;
        words_loaded_d = words_loaded_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;

        in_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                     (state_d == S_DATA) || (state_d == S_CSUM);
        busy_d     = in_ready_d;
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
        cpu_hold_d = (state_d != S_DONE);

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    words_loaded_d = '0;
                    csum_d         = '0;
                    byte_idx_d     = '0;
                end
            end
            S_LEN0: begin
                if (accept_c) len_d[7:0] = in_byte;
            end
            S_LEN1: begin
                if (accept_c) len_d[15:8] = in_byte;
            end
            S_DATA: begin
                if (accept_c) begin
                    csum_d     = csum_q ^ in_byte;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_buf_d[7:0]   = in_byte;
                        2'd1: word_buf_d[15:8]  = in_byte;
                        2'd2: word_buf_d[23:16] = in_byte;
                        default: begin
                            wr_data_d      = {in_byte, word_buf_q};
                            wr_addr_d      = BASE_ADDR + {14'd0, words_loaded_q, 2'b00};
                            wr_en_d        = 1'b1;
                            words_loaded_d = words_loaded_q + 16'd1;
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign in_ready     = in_ready_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign words_loaded = words_loaded_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign cpu_hold     = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench. Load tasks derive the expected memory
// writes and final status from the stream itself; a monitor pops and compares
// every write strobe independently of the stimulus.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam int          MAXW = 1024;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [15:0] words_loaded;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clock(clk), .reset(rst_n), .start(start), .in_byte(in_byte),
        .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .words_loaded(words_loaded),
        .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] exp_q[$];   // {addr, data} of each expected write
    logic [7:0]  stim_q[$];  // data bytes of the next load
    logic [63:0] mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(posedge clk) begin
        #1;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected none",
                         wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check32("wr_addr", wr_addr, mon_e[63:32]);
                check32("wr_data", wr_data, mon_e[31:0]);
            end
        end
    end

    // Watchdog keeps the run bounded even if a handshake never completes
    initial begin
        #900_000;
        miscompares++;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    task automatic check_reset_vals(input string tag);
        check32({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check32({tag, "_wr_en"},    32'(wr_en),    32'd0);
        check32({tag, "_busy"},     32'(busy),     32'd0);
        check32({tag, "_done"},     32'(done),     32'd0);
        check32({tag, "_error"},    32'(error),    32'd0);
        check32({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        check32({tag, "_wr_addr"},  wr_addr,       BASE);
        check32({tag, "_wr_data"},  wr_data,       32'd0);
        check32({tag, "_words"},    32'(words_loaded), 32'd0);
    endtask

    // Called at a negedge; returns at a negedge one cycle later
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte; gap<0 forces one idle cycle first, else random idles
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit rdy;
        bit accepted;
        int idles;
        if (gap < 0) begin
            in_valid = 1'b0;
            @(negedge clk);
        end else begin
            idles = 0;
            while (($urandom_range(0, 99) < gap) && (idles < 8)) begin
                in_valid = 1'b0;
                @(negedge clk);
                idles++;
            end
        end
        in_byte  = b;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int c = 0; c < 20 && !accepted; c++) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) accepted = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!accepted) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_timeout: byte 0x%02h got no in_ready, expected acceptance", b);
        end
    endtask

    task automatic fill_random(input int nbytes);
        stim_q.delete();
        for (int i = 0; i < nbytes; i++) stim_q.push_back(8'($urandom));
    endtask

    // One complete load of stim_q as an n-word program
    task automatic do_load(input int n, input bit use_csum, input logic [7:0] csum_in,
                           input int gap, input bit start_mid, input string tag);
        logic [7:0]  x;
        logic [7:0]  cs;
        logic [31:0] w;
        bit          ok_len;
        bit          exp_done;
        ok_len = (n <= MAXW);
        x = 8'h00;
        if (ok_len) begin
            for (int i = 0; i < n; i++) begin
                w = {stim_q[4*i+3], stim_q[4*i+2], stim_q[4*i+1], stim_q[4*i]};
                exp_q.push_back({BASE + 32'(4 * i), w});
            end
            for (int i = 0; i < 4 * n; i++) x = x ^ stim_q[i];
        end
        cs       = use_csum ? csum_in : x;
        exp_done = ok_len && (cs == x);

        pulse_start();
        check32({tag, "_start_busy"},  32'(busy),     32'd1);
        check32({tag, "_start_ready"}, 32'(in_ready), 32'd1);
        check32({tag, "_start_done"},  32'(done),     32'd0);
        check32({tag, "_start_error"}, 32'(error),    32'd0);
        check32({tag, "_start_hold"},  32'(cpu_hold), 32'd1);
        check32({tag, "_start_words"}, 32'(words_loaded), 32'd0);

        send_byte(8'(n), gap);
        send_byte(8'(n >> 8), gap);
        if (ok_len) begin
            for (int i = 0; i < 4 * n; i++) begin
                if (start_mid && i == 2) pulse_start();
                send_byte(stim_q[i], gap);
            end
            send_byte(cs, gap);
        end
        repeat (3) @(negedge clk);

        check32({tag, "_done"},     32'(done),     32'(exp_done));
        check32({tag, "_error"},    32'(error),    32'(!exp_done));
        check32({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
        check32({tag, "_busy"},     32'(busy),     32'd0);
        check32({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check32({tag, "_words"},    32'(words_loaded), ok_len ? 32'(n) : 32'd0);
        check32({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        bit good;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_byte  = 8'h00;
        in_valid = 1'b0;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("idle");

        // Known program; XOR of the eight data bytes is 0x2A
        stim_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_load(2, 1'b1, 8'h2A, 0, 1'b0, "t1_good");
        do_load(2, 1'b1, 8'h9B, 0, 1'b0, "t2_badcsum");
        do_load(2, 1'b1, 8'h9A, 0, 1'b0, "t2b_badcsum");

        // Oversized length is rejected right after the second length byte
        stim_q.delete();
        do_load(1025, 1'b0, 8'h00, 0, 1'b0, "t3_len1025");
        do_load(65535, 1'b0, 8'h00, 0, 1'b0, "t3_len65535");

        // Valid toggling every cycle with a stray start in the middle of a word
        fill_random(4);
        do_load(1, 1'b0, 8'h00, -1, 1'b1, "t4_toggle");

        // Asynchronous reset part-way through the second word
        fill_random(12);
        exp_q.push_back({BASE, {stim_q[3], stim_q[2], stim_q[1], stim_q[0]}});
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 5; i++) send_byte(stim_q[i], 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("t5_async");
        check32("t5_pending_writes", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_random(4);
        do_load(1, 1'b0, 8'h00, 0, 1'b0, "t5_reload");

        // Empty program, then restart from DONE
        stim_q.delete();
        do_load(0, 1'b1, 8'h00, 0, 1'b0, "t6_empty");
        do_load(0, 1'b1, 8'h01, 0, 1'b0, "t6_empty_bad");
        do_load(0, 1'b1, 8'h00, 0, 1'b0, "t6_restart");

        // Largest accepted program at full rate
        fill_random(4 * MAXW);
        do_load(MAXW, 1'b0, 8'h00, 0, 1'b0, "max_words");

        // Randomized loads with random pacing and checksum faults
        for (int k = 0; k < 24; k++) begin
            n    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            good = ($urandom_range(0, 3) != 0);
            fill_random(4 * n);
            do_load(n, !good, 8'($urandom_range(0, 255)) ^ 8'h00, int'($urandom_range(0, 60)),
                    1'b0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
